// File: rtl/gcd_stream_if.sv
// gcd_stream_if: operand/result handshake bundle for gcd_stream.
//   slave  modport : view of the GCD block (consumes operands, produces result)
//   master modport : view of the producer/consumer driving the block
// Signals:
//   io_in_valid/io_in_ready   operand pair handshake
//   io_in_bits_a/io_in_bits_b operands (WIDTH bits)
//   io_out_valid/io_out_ready result handshake
//   io_out_bits               GCD result (WIDTH bits)
//   io_out_cycles             CALC cycle count (only with GCD_CYCLE_COUNT_EN)
interface gcd_stream_if #(
  parameter int unsigned WIDTH     = 16
`ifdef GCD_CYCLE_COUNT_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
);
  logic             io_in_ready;
  logic             io_in_valid;
  logic [WIDTH-1:0] io_in_bits_a;
  logic [WIDTH-1:0] io_in_bits_b;
  logic             io_out_ready;
  logic             io_out_valid;
  logic [WIDTH-1:0] io_out_bits;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] io_out_cycles;
`endif

  modport slave (
    output io_in_ready,
    input  io_in_valid,
    input  io_in_bits_a,
    input  io_in_bits_b,
    input  io_out_ready,
    output io_out_valid,
    output io_out_bits
`ifdef GCD_CYCLE_COUNT_EN
    , output io_out_cycles
`endif
  );

  modport master (
    input  io_in_ready,
    output io_in_valid,
    output io_in_bits_a,
    output io_in_bits_b,
    output io_out_ready,
    input  io_out_valid,
    input  io_out_bits
`ifdef GCD_CYCLE_COUNT_EN
    , input  io_out_cycles
`endif
  );
endinterface

// File: rtl/gcd_stream.sv
// gcd_stream: streaming GCD stage using Euclid subtraction with swap.
// One operand pair in flight at a time; result held until consumed.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   io     gcd_stream_if.slave (operand handshake in, result handshake out)
// Optional feature macro: GCD_CYCLE_COUNT_EN adds a saturating CALC cycle
// counter presented on io.io_out_cycles.
module gcd_stream #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  gcd_stream_if.slave  io
);

  if (WIDTH < 2 || CNT_WIDTH < 1) begin : g_bad_param
    $error("gcd_stream: WIDTH must be >= 2 and CNT_WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef GCD_CYCLE_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.io_in_valid) begin
          a_d     = io.io_in_bits_a;
          b_d     = io.io_in_bits_b;
          state_d = CALC;
`ifdef GCD_CYCLE_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
        // Saturate rather than wrap so long runs read as "at least max".
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
`endif
        // Zero checks come first so gcd(x,0), gcd(0,x), gcd(0,0) finish
        // in one cycle and the subtract loop never spins on a zero operand.
        if (b_q == '0) begin
          res_d   = a_q;
          state_d = DONE;
        end else if (a_q == '0) begin
          res_d   = b_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      DONE: begin
        if (io.io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.io_in_ready  = (state_q == IDLE);
  assign io.io_out_valid = (state_q == DONE);
  assign io.io_out_bits  = res_q;
`ifdef GCD_CYCLE_COUNT_EN
  assign io.io_out_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_stream.sv
module tb_gcd_stream;
  localparam int unsigned WIDTH = 16;
  localparam int LIMIT = 70000;

  logic clock;
  logic reset;
  int   total;
  int   bad;

`ifdef GCD_CYCLE_COUNT_EN
  gcd_stream_if #(.WIDTH(WIDTH), .CNT_WIDTH(16)) io();
  gcd_stream #(.WIDTH(WIDTH), .CNT_WIDTH(16)) dut (.clock(clock), .reset(reset), .io(io));
`else
  gcd_stream_if #(.WIDTH(WIDTH)) io();
  gcd_stream #(.WIDTH(WIDTH), .CNT_WIDTH(16)) dut (.clock(clock), .reset(reset), .io(io));
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic accept(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    while (!io.io_in_ready && n < 100) begin
      @(posedge clock); #1; n++;
    end
    check({tag, "_ready"}, 32'(io.io_in_ready), 1);
    io.io_in_valid  = 1'b1;
    io.io_in_bits_a = a;
    io.io_in_bits_b = b;
    @(posedge clock); #1;
    io.io_in_valid  = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!io.io_out_valid && n < LIMIT);
    check({tag, "_valid"}, 32'(io.io_out_valid), 1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int exp_res, input int exp_n, input int exp_cyc);
    int n;
    accept(tag, a, b);
    wait_valid(tag, n);
    check({tag, "_lat"}, n, exp_n);
    check({tag, "_res"}, 32'(io.io_out_bits), exp_res);
`ifdef GCD_CYCLE_COUNT_EN
    check({tag, "_cyc"}, 32'(io.io_out_cycles), exp_cyc);
`endif
    // io_out_ready is high, so valid lasts one cycle and IDLE follows.
    @(posedge clock); #1;
    check({tag, "_vld_drop"}, 32'(io.io_out_valid), 0);
    check({tag, "_idle"}, 32'(io.io_in_ready), 1);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    io.io_in_valid  = 1'b0;
    io.io_in_bits_a = '0;
    io.io_in_bits_b = '0;
    io.io_out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", 32'(io.io_in_ready), 1);
    check("rst_valid", 32'(io.io_out_valid), 0);
    check("rst_bits", 32'(io.io_out_bits), 0);
`ifdef GCD_CYCLE_COUNT_EN
    check("rst_cyc", 32'(io.io_out_cycles), 0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("g12_8", 16'd12, 16'd8, 4, 6, 6);
    run_op("g0_0", 16'd0, 16'd0, 0, 1, 1);
    run_op("g7_0", 16'd7, 16'd0, 7, 1, 1);
    run_op("g0_9", 16'd0, 16'd9, 9, 1, 1);

    // Backpressure: result held, inputs ignored while DONE.
    io.io_out_ready = 1'b0;
    accept("bp", 16'd21, 16'd6);
    wait_valid("bp", n);
    check("bp_lat", n, 8);
    for (int i = 0; i < 5; i++) begin
      io.io_in_valid  = (i % 2 == 0);
      io.io_in_bits_a = 16'd100;
      io.io_in_bits_b = 16'd50;
      @(posedge clock); #1;
      check("bp_hold_valid", 32'(io.io_out_valid), 1);
      check("bp_hold_bits", 32'(io.io_out_bits), 3);
      check("bp_hold_ready", 32'(io.io_in_ready), 0);
`ifdef GCD_CYCLE_COUNT_EN
      check("bp_hold_cyc", 32'(io.io_out_cycles), 8);
`endif
    end
    io.io_in_valid  = 1'b0;
    io.io_out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_exit_ready", 32'(io.io_in_ready), 1);
    check("bp_exit_valid", 32'(io.io_out_valid), 0);
    check("bp_keep_bits", 32'(io.io_out_bits), 3);

    // Reset aborts a long-running operation.
    accept("abort", 16'd1000, 16'd3);
    repeat (5) @(posedge clock);
    #1;
    check("abort_busy", 32'(io.io_in_ready), 0);
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(io.io_out_valid), 0);
    check("abort_ready", 32'(io.io_in_ready), 1);
    check("abort_bits", 32'(io.io_out_bits), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    run_op("g9_6", 16'd9, 16'd6, 3, 6, 6);

    // Back-to-back: second pair offered from the cycle the first is taken.
    accept("b2b1", 16'd12, 16'd8);
    wait_valid("b2b1", n);
    check("b2b1_res", 32'(io.io_out_bits), 4);
    io.io_in_valid  = 1'b1;
    io.io_in_bits_a = 16'd35;
    io.io_in_bits_b = 16'd14;
    @(posedge clock); #1;
    check("b2b_idle", 32'(io.io_in_ready), 1);
    check("b2b_vld_drop", 32'(io.io_out_valid), 0);
    @(posedge clock); #1;
    check("b2b_taken", 32'(io.io_in_ready), 0);
    io.io_in_valid = 1'b0;
    wait_valid("b2b2", n);
    check("b2b2_lat", n, 7);
    check("b2b2_res", 32'(io.io_out_bits), 7);
`ifdef GCD_CYCLE_COUNT_EN
    check("b2b2_cyc", 32'(io.io_out_cycles), 7);
`endif
    @(posedge clock); #1;

    // Worst case: long subtraction chain, counter saturates.
    run_op("gmax_1", 16'hFFFF, 16'd1, 1, 65537, 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
